md_unit: RTL and testbench
==========================

# md_unit

Parametrised multiply/divide unit for the pipelined MIPS core. It sits beside the EX-stage ALU and executes mult, multu, div, divu, mthi and mtlo. It also implements the accumulate family madd, maddu, msub and msubu, which no earlier unit supported. HI/LO are held internally, multi-cycle latency is configurable, and the `busy` output feeds the hazard/stall logic.

## Interface
- `WIDTH`, default 32: operand width; HI and LO are each `WIDTH` bits.
- `MULT_CYCLES`, default 5: busy cycles for mult/madd/msub ops; legal range is 1 or more.
- `DIV_CYCLES`, default 10: busy cycles for div ops; legal range is 1 or more.
- `clk`  in  1  the single clock.
- `reset`  in  1  reset, asynchronous and active-high.
- `start`  in  1  issue strobe, qualified by `md_op`.
- `md_op`  in  4  operation code, see `md_pkg`.
- `rs_val`  in  WIDTH  operand A; this is the value written by mthi/mtlo.
- `rt_val`  in  WIDTH  operand B.
- `busy`  out  1  a multi-cycle operation is in flight.
- `hi`  out  WIDTH  architectural HI, read by mfhi.
- `lo`  out  WIDTH  architectural LO, read by mflo.

## Operation
- Op codes: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU. Codes 11–15 are treated as NONE.
- Accept rule: an op is accepted on a rising edge where `start`=1, `busy`=0 and the op is not NONE. When `busy`=1, `start` is ignored entirely, including MTHI/MTLO; the stall unit must hold the instruction.
- MTHI/MTLO: `hi` or `lo` takes `rs_val` at the accepting edge. `busy` is not raised.
- Multi-cycle ops: the result is computed from the operands latched at accept and stored in a pending {HI,LO} register. A down-counter is loaded with the latency. Architectural HI/LO change only at completion.
- MULT/MULTU: {HI,LO} = A×B, a 2·WIDTH-bit product, signed or unsigned per op.
- MADD/MADDU: {HI,LO} = {HI,LO} + A×B, taken modulo 2^(2·WIDTH). The {HI,LO} value used is the one present at accept.
- MSUB/MSUBU: {HI,LO} = {HI,LO} − A×B, taken modulo 2^(2·WIDTH).
- DIV: LO = quotient truncated toward zero; HI = remainder, carrying the sign of the dividend.
- DIV overflow: for −2^(WIDTH−1) / −1, LO = −2^(WIDTH−1) and HI = 0.
- DIVU: unsigned quotient to LO, unsigned remainder to HI.
- Divide by zero (rt_val=0): the unit still goes busy for DIV_CYCLES, but HI/LO are left unchanged at completion.
- State machine has two states:
  - IDLE → BUSY on accept of a multi-cycle op, with counter = latency.
  - BUSY decrements the counter each cycle; when it reaches 1, the next edge commits and returns to IDLE.

## Timing
- Reset: `busy`=0, `hi`=0, `lo`=0, counter=0, pending register cleared, state IDLE.
- Reset mid-operation: the in-flight op is discarded and its result is never committed.
- Multi-cycle accept at edge k:
  - `busy`=1 from after edge k until edge k+N, where N is the latency.
  - HI/LO are updated at edge k+N, and `busy` falls at the same edge.
  - A new op may be accepted at edge k+N+1 at the earliest.
- Back-to-back ops: there is no bubble beyond the above. An accumulate issued at k+N+1 sees the HI/LO committed at k+N.
- MTHI/MTLO: zero-latency; the new value is visible on `hi`/`lo` right after the accepting edge.
- `hi`, `lo` and `busy` are registered outputs with no combinational path from the inputs.

## Structure
- Package `md_pkg` holds:
  - the `md_op` localparams (MD_NONE … MD_MSUBU);
  - the op-class helpers `is_mul_class` and `is_div_class`.
- Sub-module `md_calc` is purely combinational and maps (op, A, B, HI, LO) to the next {HI,LO} plus a divide-by-zero flag.
- `md_unit` itself holds the FSM, counter, pending register and architectural HI/LO.

## Test plan
- MULT with A=0xFFFFFFFF, B=2 → `busy` high for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE. MULTU with the same operands → hi=0x00000001, lo=0xFFFFFFFE.
- DIV with A=−7 (0xFFFFFFF9), B=2 → after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU with A=7, B=0 and prior hi/lo=0x11/0x22 → `busy` for 10 cycles, then hi/lo still 0x11/0x22.
- MTHI 0x5 → hi=0x5 next cycle. Then MADD with A=3, B=4, lo=0 → {hi,lo}=0x00000005_0000000C. Then MSUBU with A=1, B=0xD → hi=0x4, lo=0xFFFFFFFF.
- Issue MULT and assert `start` with MTLO 0x99 while `busy` → the MTLO is ignored and lo is never 0x99. Re-issuing after `busy` falls → lo=0x99.
- Assert `reset` on the 3rd busy cycle of a DIV → `busy`=0 and hi=lo=0 immediately; no later commit occurs.
- Run with MULT_CYCLES=1, DIV_CYCLES=3 → MULT commits at edge k+1 and DIV at edge k+3, with `busy` widths of 1 and 3 respectively.

Source files
------------

// File: rtl/md_pkg.sv
// Shared op codes, FSM state type and op-class helpers for the multiply/divide unit.
package md_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MTHI  = 4'd5;
  localparam logic [3:0] MD_MTLO  = 4'd6;
  localparam logic [3:0] MD_MADD  = 4'd7;
  localparam logic [3:0] MD_MADDU = 4'd8;
  localparam logic [3:0] MD_MSUB  = 4'd9;
  localparam logic [3:0] MD_MSUBU = 4'd10;

  typedef enum logic {ST_IDLE, ST_BUSY} md_state_t;

  function automatic logic is_mul_class(input logic [3:0] op);
    return op inside {MD_MULT, MD_MULTU, MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU};
  endfunction

  function automatic logic is_div_class(input logic [3:0] op);
    return op inside {MD_DIV, MD_DIVU};
  endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational result generator: maps (op, A, B, HI, LO) to the next {HI,LO}.
module md_calc
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] next_hi,
  output logic [WIDTH-1:0] next_lo,
  output logic             div_zero
);

  localparam int W2 = 2 * WIDTH;

  logic signed [W2-1:0]    a_sx, b_sx, prod_s;
  logic        [W2-1:0]    prod_u, acc, result;
  logic signed [WIDTH-1:0] a_s, b_s, quo_s, rem_s;
  logic        [WIDTH-1:0] quo_u, rem_u;
  logic                    div_ovf;

  assign a_sx     = {{WIDTH{a[WIDTH-1]}}, a};
  assign b_sx     = {{WIDTH{b[WIDTH-1]}}, b};
  assign prod_s   = a_sx * b_sx;
  assign prod_u   = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
  assign acc      = {hi, lo};
  assign a_s      = a;
  assign b_s      = b;
  assign div_zero = (b == '0);
  // Most-negative / -1 overflows the quotient; pin it to the dividend with zero remainder.
  assign div_ovf  = (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);

  // Quotient/remainder, guarded so a zero divisor never reaches the dividers
  always_comb begin
    quo_s = '0;
    rem_s = '0;
    quo_u = '0;
    rem_u = '0;
    if (!div_zero) begin
      if (div_ovf) begin
        quo_s = a_s;
        rem_s = '0;
      end else begin
        quo_s = a_s / b_s;
        rem_s = a_s % b_s;
      end
      quo_u = a / b;
      rem_u = a % b;
    end
  end

  // Select the 2*WIDTH result for the op; unknown ops and divide-by-zero keep {HI,LO}
  always_comb begin
    result = acc;
    case (op)
      MD_MULT:  result = prod_s;
      MD_MULTU: result = prod_u;
      MD_MADD:  result = acc + prod_s;
      MD_MADDU: result = acc + prod_u;
      MD_MSUB:  result = acc - prod_s;
      MD_MSUBU: result = acc - prod_u;
      MD_DIV:   if (!div_zero) result = {rem_s, quo_s};
      MD_DIVU:  if (!div_zero) result = {rem_u, quo_u};
      default:  result = acc;
    endcase
  end

  assign next_hi = result[W2-1:WIDTH];
  assign next_lo = result[WIDTH-1:0];

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with internal HI/LO, latency counter and busy flag.
module md_unit
  import md_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       md_op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] MUL_LAT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LAT = CNT_W'(DIV_CYCLES);

  md_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] pend_hi, pend_lo;
  logic             pend_skip;
  logic [WIDTH-1:0] calc_hi, calc_lo;
  logic             calc_dz;
  logic             accept;

  // Accumulates read the architectural HI/LO as they stand at the accepting edge
  md_calc #(.WIDTH(WIDTH)) u_calc (
    .op       (md_op),
    .a        (rs_val),
    .b        (rt_val),
    .hi       (hi),
    .lo       (lo),
    .next_hi  (calc_hi),
    .next_lo  (calc_lo),
    .div_zero (calc_dz)
  );

  assign accept = start && !busy && (md_op != MD_NONE);

  // FSM: accept in IDLE, count down in BUSY, commit pending result on the last count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      cnt       <= '0;
      pend_hi   <= '0;
      pend_lo   <= '0;
      pend_skip <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (md_op == MD_MTHI) begin
              hi <= rs_val;
            end else if (md_op == MD_MTLO) begin
              lo <= rs_val;
            end else if (is_mul_class(md_op) || is_div_class(md_op)) begin
              pend_hi   <= calc_hi;
              pend_lo   <= calc_lo;
              pend_skip <= is_div_class(md_op) && calc_dz;
              cnt       <= is_div_class(md_op) ? DIV_LAT : MUL_LAT;
              busy      <= 1'b1;
              state     <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          if (cnt == CNT_W'(1)) begin
            if (!pend_skip) begin
              hi <= pend_hi;
              lo <= pend_lo;
            end
            busy  <= 1'b0;
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: default-latency instance plus a fast (1/3 cycle) instance.
module tb_md_unit;
  import md_pkg::*;

  logic        clk;
  logic        reset, start;
  logic [3:0]  md_op;
  logic [31:0] rs_val, rt_val, hi, lo;
  logic        busy;
  logic        reset2, start2;
  logic [3:0]  md_op2;
  logic [31:0] rs_val2, rt_val2, hi2, lo2;
  logic        busy2;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_hi [2];
  logic [31:0] m_lo [2];

  md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .rs_val(rs_val), .rt_val(rt_val), .busy(busy), .hi(hi), .lo(lo)
  );

  md_unit #(.WIDTH(32), .MULT_CYCLES(1), .DIV_CYCLES(3)) dut_fast (
    .clk(clk), .reset(reset2), .start(start2), .md_op(md_op2),
    .rs_val(rs_val2), .rt_val(rt_val2), .busy(busy2), .hi(hi2), .lo(lo2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic busy_of(input bit sel);
    return sel ? busy2 : busy;
  endfunction
  function automatic logic [31:0] hi_of(input bit sel);
    return sel ? hi2 : hi;
  endfunction
  function automatic logic [31:0] lo_of(input bit sel);
    return sel ? lo2 : lo;
  endfunction

  function automatic int exp_lat(input bit sel, input logic [3:0] op);
    if (op == 4'd3 || op == 4'd4) return sel ? 3 : 10;
    return sel ? 1 : 5;
  endfunction

  // Reference model: architectural effect of one accepted op, in plain 64-bit arithmetic
  function automatic void model_apply(input bit sel, input logic [3:0] op,
                                      input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, acc, ps, pu, res;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    acc = {m_hi[sel], m_lo[sel]};
    ps  = sa * sb;
    pu  = ua * ub;
    res = acc;
    case (op)
      4'd1:  res = ps;
      4'd2:  res = pu;
      4'd3:  if (b != 0) begin q = sa / sb; r = sa % sb; res = {r[31:0], q[31:0]}; end
      4'd4:  if (b != 0) begin res = {32'(ua % ub), 32'(ua / ub)}; end
      4'd5:  res = {a, m_lo[sel]};
      4'd6:  res = {m_hi[sel], a};
      4'd7:  res = acc + ps;
      4'd8:  res = acc + pu;
      4'd9:  res = acc - ps;
      4'd10: res = acc - pu;
      default: res = acc;
    endcase
    m_hi[sel] = res[63:32];
    m_lo[sel] = res[31:0];
  endfunction

  // Present one op for exactly one rising edge; returns 1 time unit after that edge
  task automatic issue(input bit sel, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    if (sel) begin start2 = 1'b1; md_op2 = op; rs_val2 = a; rt_val2 = b; end
    else     begin start  = 1'b1; md_op  = op; rs_val  = a; rt_val  = b; end
    @(posedge clk);
    #1;
    if (sel) start2 = 1'b0; else start = 1'b0;
  endtask

  task automatic run_mc(input bit sel, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input string name);
    logic [31:0] old_hi, old_lo;
    int n, cyc;
    old_hi = m_hi[sel];
    old_lo = m_lo[sel];
    n = exp_lat(sel, op);
    model_apply(sel, op, a, b);
    issue(sel, op, a, b);
    checks++;
    if (busy_of(sel) !== 1'b1 || hi_of(sel) !== old_hi || lo_of(sel) !== old_lo) begin
      errors++;
      $display("FAIL %s_accept: busy=%0b hi=%h lo=%h, required busy=1 hi=%h lo=%h",
               name, busy_of(sel), hi_of(sel), lo_of(sel), old_hi, old_lo);
    end
    cyc = 0;
    while (busy_of(sel) === 1'b1 && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (busy_of(sel) === 1'b1) begin
        checks++;
        if (hi_of(sel) !== old_hi || lo_of(sel) !== old_lo) begin
          errors++;
          $display("FAIL %s_early_commit: cycle %0d hi=%h lo=%h, required hi=%h lo=%h",
                   name, cyc, hi_of(sel), lo_of(sel), old_hi, old_lo);
        end
      end
    end
    checks++;
    if (cyc != n) begin
      errors++;
      $display("FAIL %s_busy_width: got %0d cycles, required %0d", name, cyc, n);
    end
    checks++;
    if (hi_of(sel) !== m_hi[sel] || lo_of(sel) !== m_lo[sel]) begin
      errors++;
      $display("FAIL %s_result: hi=%h lo=%h, required hi=%h lo=%h",
               name, hi_of(sel), lo_of(sel), m_hi[sel], m_lo[sel]);
    end
  endtask

  task automatic run_mt(input bit sel, input logic [3:0] op, input logic [31:0] a, input string name);
    model_apply(sel, op, a, 32'd0);
    issue(sel, op, a, $urandom);
    checks++;
    if (busy_of(sel) !== 1'b0 || hi_of(sel) !== m_hi[sel] || lo_of(sel) !== m_lo[sel]) begin
      errors++;
      $display("FAIL %s: busy=%0b hi=%h lo=%h, required busy=0 hi=%h lo=%h",
               name, busy_of(sel), hi_of(sel), lo_of(sel), m_hi[sel], m_lo[sel]);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; reset2 = 1'b1;
    start = 1'b0; start2 = 1'b0;
    md_op = 4'd0; md_op2 = 4'd0;
    rs_val = '0; rt_val = '0; rs_val2 = '0; rt_val2 = '0;
    for (int i = 0; i < 2; i++) begin m_hi[i] = '0; m_lo[i] = '0; end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: busy=%0b hi=%h lo=%h, required 0/0/0", busy, hi, lo);
    end
    checks++;
    if (busy2 !== 1'b0 || hi2 !== 32'd0 || lo2 !== 32'd0) begin
      errors++;
      $display("FAIL reset_state_fast: busy=%0b hi=%h lo=%h, required 0/0/0", busy2, hi2, lo2);
    end
    @(negedge clk);
    reset = 1'b0; reset2 = 1'b0;
  endtask

  task automatic test_mult;
    run_mc(0, MD_MULT,  32'hFFFF_FFFF, 32'd2, "mult_neg1x2");
    run_mc(0, MD_MULTU, 32'hFFFF_FFFF, 32'd2, "multu_max_x2");
    run_mc(0, MD_MULT,  32'h8000_0000, 32'h8000_0000, "mult_minxmin");
  endtask

  task automatic test_div;
    run_mc(0, MD_DIV,  32'hFFFF_FFF9, 32'd2, "div_m7_by_2");
    run_mc(0, MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
    run_mt(0, MD_MTHI, 32'h11, "mthi_11");
    run_mt(0, MD_MTLO, 32'h22, "mtlo_22");
    run_mc(0, MD_DIVU, 32'd7, 32'd0, "divu_by_zero");
    run_mc(0, MD_DIV,  32'd7, 32'd0, "div_by_zero");
    run_mc(0, MD_DIVU, 32'hFFFF_FFF9, 32'd2, "divu_big");
  endtask

  task automatic test_accumulate;
    run_mt(0, MD_MTLO, 32'd0, "mtlo_0");
    run_mt(0, MD_MTHI, 32'h5, "mthi_5");
    run_mc(0, MD_MADD,  32'd3, 32'd4,   "madd_3x4");
    run_mc(0, MD_MSUBU, 32'd1, 32'hD,   "msubu_1xd");
    run_mc(0, MD_MSUB,  32'hFFFF_FFFE, 32'd3, "msub_neg");
    run_mc(0, MD_MADDU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "maddu_max");
  endtask

  task automatic test_back_to_back;
    run_mc(0, MD_MULT, 32'd1000, 32'd1000, "b2b_mult");
    run_mc(0, MD_MADD, 32'd7, 32'd9, "b2b_madd");
    run_mc(0, MD_DIVU, 32'd1_000_000, 32'd999, "b2b_divu");
  endtask

  task automatic test_busy_ignore;
    int cyc;
    run_mt(0, MD_MTLO, 32'd0, "ign_prep");
    model_apply(0, MD_MULT, 32'd3, 32'd5);
    issue(0, MD_MULT, 32'd3, 32'd5);
    cyc = 0;
    while (busy === 1'b1 && cyc < 40) begin
      @(negedge clk);
      start = 1'b1; md_op = MD_MTLO; rs_val = 32'h99; rt_val = 32'd0;
      @(posedge clk);
      #1;
      cyc++;
      checks++;
      if (lo === 32'h99) begin
        errors++;
        $display("FAIL ignore_mtlo_while_busy: lo=%h at cycle %0d, required not 00000099", lo, cyc);
      end
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (hi !== m_hi[0] || lo !== m_lo[0] || cyc != 5) begin
      errors++;
      $display("FAIL ignore_mult_result: hi=%h lo=%h width=%0d, required hi=%h lo=%h width=5",
               hi, lo, cyc, m_hi[0], m_lo[0]);
    end
    run_mt(0, MD_MTLO, 32'h99, "mtlo_reissue");
  endtask

  task automatic test_reset_mid;
    run_mt(0, MD_MTHI, 32'hABC, "pre_reset_mthi");
    run_mt(0, MD_MTLO, 32'hDEF, "pre_reset_mtlo");
    issue(0, MD_DIV, 32'd100, 32'd7);
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1;
    #1;
    m_hi[0] = '0;
    m_lo[0] = '0;
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_immediate: busy=%0b hi=%h lo=%h, required 0/0/0", busy, hi, lo);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_no_commit: busy=%0b hi=%h lo=%h, required 0/0/0", busy, hi, lo);
    end
  endtask

  task automatic test_fast_latency;
    run_mc(1, MD_MULT, 32'hFFFF_FFFF, 32'd2, "fast_mult");
    run_mc(1, MD_DIV,  32'hFFFF_FFF9, 32'd2, "fast_div");
    run_mc(1, MD_MADD, 32'd5, 32'd6, "fast_madd");
  endtask

  task automatic run_random(input bit sel, input int count);
    logic [3:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < count; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      case ($urandom_range(0, 4))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 20));
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      if ((op >= 4'd1 && op <= 4'd4) || (op >= 4'd7 && op <= 4'd10)) begin
        run_mc(sel, op, a, b, "rand_mc");
      end else if (op == 4'd5 || op == 4'd6) begin
        run_mt(sel, op, a, "rand_mt");
      end else begin
        issue(sel, op, a, b);
        checks++;
        if (busy_of(sel) !== 1'b0 || hi_of(sel) !== m_hi[sel] || lo_of(sel) !== m_lo[sel]) begin
          errors++;
          $display("FAIL rand_none op=%0d: busy=%0b hi=%h lo=%h, required busy=0 hi=%h lo=%h",
                   op, busy_of(sel), hi_of(sel), lo_of(sel), m_hi[sel], m_lo[sel]);
        end
      end
    end
  endtask

  task automatic test_random;
    run_random(0, 30);
    run_random(1, 20);
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_accumulate();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid();
    test_fast_latency();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
